// File: rtl/usb_func_mux_pkg.sv
// Shared constants for the USB function multiplexer: register offsets,
// status/control bit positions and the switch state machine encoding.
package usb_func_mux_pkg;

  // Word-aligned register byte offsets
  localparam logic [3:0] AddrCcr = 4'h0;
  localparam logic [3:0] AddrRdr = 4'h4;
  localparam logic [3:0] AddrTdr = 4'h8;
  localparam logic [3:0] AddrSta = 4'hC;

  // STA bit positions
  localparam int unsigned StaConn     = 0;
  localparam int unsigned StaRxEmpty  = 1;
  localparam int unsigned StaRxFull   = 2;
  localparam int unsigned StaRxOvf    = 3;
  localparam int unsigned StaTxBusy   = 4;
  localparam int unsigned StaSwitch   = 5;
  localparam int unsigned StaTxOvf    = 6;
  localparam int unsigned StaConnChg  = 7;
  localparam int unsigned StaLevelLsb = 8;

  // CCR field positions
  localparam int unsigned CcrSelLsb = 0;
  localparam int unsigned CcrIeLsb  = 24;
  localparam int unsigned CcrEn     = 31;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDetach = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/usb_rx_fifo.sv
// RX word FIFO between the selected USB function and the CPU.
// Ports: clk_i/rst_i (async active-high), flush_i empties the FIFO, push_i/wdata_i
// write (ignored when full), pop_i (ignored when empty), rdata_o is the head word,
// level_o/full_o/empty_o report occupancy. DEPTH must be a power of two.
module usb_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   wdata_i,
  input  logic          pop_i,
  output logic [31:0]   rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/usb_func_mux.sv
// Software-controlled multiplexer connecting one of N_FUNC USB function cores to a
// shared D+/D- pad pair. Every CCR write forces a timed detach (pull-up off, all
// functions in reset) so the host sees a disconnect before the new function appears.
// Ports: bus (write_i/read_i/data_be_i/addr_i/wdata_i/rdata_o), per-function reset,
// pad request, RX and TX handshakes, and the shared pad outputs (usb_*_o).
// Optional: define USB_FUNC_MUX_IRQ_EN to add irq_o, CCR[27:24] interrupt enables
// and the sticky connect-change flag STA[7].
module usb_func_mux
  import usb_func_mux_pkg::*;
#(
  parameter int unsigned N_FUNC        = 6,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned DETACH_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_i,
  input  logic                  read_i,
  input  logic [3:0]            data_be_i,
  input  logic [3:0]            addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic [N_FUNC-1:0]     func_rstn_o,
  input  logic [N_FUNC-1:0]     func_pull_i,
  input  logic [N_FUNC-1:0]     func_oe_i,
  input  logic [N_FUNC-1:0]     func_dp_i,
  input  logic [N_FUNC-1:0]     func_dn_i,
  input  logic [N_FUNC-1:0]     func_conn_i,
  input  logic [N_FUNC-1:0]     func_rx_valid_i,
  input  logic [32*N_FUNC-1:0]  func_rx_data_i,
  output logic [N_FUNC-1:0]     func_rx_ready_o,
  output logic [31:0]           func_tx_data_o,
  output logic [N_FUNC-1:0]     func_tx_valid_o,
  input  logic [N_FUNC-1:0]     func_tx_ready_i,
`ifdef USB_FUNC_MUX_IRQ_EN
  output logic                  irq_o,
`endif
  output logic                  usb_dp_pull_o,
  output logic                  usb_oe_o,
  output logic                  usb_dp_o,
  output logic                  usb_dn_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = $clog2(DETACH_CYCLES);
  localparam logic [CW-1:0] CntLoad = CW'(DETACH_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    ccr_sel_q;
  logic          ccr_en_q;
  logic [31:0]   tx_data_q, rdata_q;
  logic          tx_busy_q, rx_ovf_q, tx_ovf_q;
  logic [3:0]    ccr_ie;
  logic          conn_chg;

  logic          active, sel_ok;
  logic [N_FUNC-1:0] sel_oh;
  logic [31:0]   wmask, rx_word, sta_word, ccr_word, rd_word;
  logic          wr_ccr, wr_tdr, wr_sta_lo, rd_rdr;
  logic          rx_valid_sel, tx_ready_sel, conn_sel;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_rdata;
  logic [LW-1:0] fifo_level;

  assign active = (state_q == StActive);
  assign sel_ok = 32'(ccr_sel_q) < N_FUNC;
  assign wmask  = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};

  assign wr_ccr    = write_i && (addr_i == AddrCcr) && (data_be_i != 4'b0);
  assign wr_tdr    = write_i && (addr_i == AddrTdr);
  assign wr_sta_lo = write_i && (addr_i == AddrSta) && data_be_i[0];
  assign rd_rdr    = read_i && (addr_i == AddrRdr);

  // One-hot of the connected function; all-zero outside ACTIVE, so every
  // per-function output below is gated by the state for free.
  always_comb begin
    sel_oh  = '0;
    rx_word = '0;
    for (int k = 0; k < N_FUNC; k++) begin
      sel_oh[k] = active && (ccr_sel_q == 4'(k));
      if (sel_oh[k]) rx_word = rx_word | func_rx_data_i[32*k +: 32];
    end
  end

  assign func_rstn_o     = sel_oh;
  assign usb_dp_pull_o   = |(func_pull_i & sel_oh);
  assign usb_oe_o        = |(func_oe_i & sel_oh);
  assign usb_dp_o        = |(func_dp_i & sel_oh);
  assign usb_dn_o        = |(func_dn_i & sel_oh);
  assign conn_sel        = |(func_conn_i & sel_oh);
  assign rx_valid_sel    = |(func_rx_valid_i & sel_oh);
  assign tx_ready_sel    = |(func_tx_ready_i & sel_oh);
  assign func_rx_ready_o = sel_oh & {N_FUNC{!fifo_full}};
  assign func_tx_valid_o = sel_oh & {N_FUNC{tx_busy_q}};
  assign func_tx_data_o  = tx_data_q;
  assign rdata_o         = rdata_q;

  assign fifo_push = rx_valid_sel && !fifo_full;
  assign fifo_pop  = rd_rdr && !fifo_empty;

  usb_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (wr_ccr),
    .push_i  (fifo_push),
    .wdata_i (rx_word),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Switch state machine; a CCR write always (re)starts the detach window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (wr_ccr) begin
      state_q <= StDetach;
      cnt_q   <= CntLoad;
    end else if (state_q == StDetach) begin
      if (cnt_q == '0) state_q <= (ccr_en_q && sel_ok) ? StActive : StIdle;
      else             cnt_q   <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ccr_sel_q <= '0;
      ccr_en_q  <= 1'b0;
      tx_data_q <= '0;
      tx_busy_q <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (write_i && (addr_i == AddrCcr)) begin
        if (data_be_i[0]) ccr_sel_q <= wdata_i[CcrSelLsb +: 4];
        if (data_be_i[3]) ccr_en_q  <= wdata_i[CcrEn];
      end
      // Later assignments win: load beats completion, a switch beats both.
      if (tx_busy_q && tx_ready_sel) tx_busy_q <= 1'b0;
      if (wr_tdr && active && !tx_busy_q) begin
        tx_data_q <= wdata_i & wmask;
        tx_busy_q <= 1'b1;
      end
      if (wr_ccr) tx_busy_q <= 1'b0;
      // Sticky flags: a set in the same cycle as a W1C clear wins.
      rx_ovf_q <= (rx_valid_sel && fifo_full) ||
                  (rx_ovf_q && !(wr_sta_lo && wdata_i[StaRxOvf]));
      tx_ovf_q <= (wr_tdr && (!active || tx_busy_q)) ||
                  (tx_ovf_q && !(wr_sta_lo && wdata_i[StaTxOvf]));
      if (read_i) rdata_q <= rd_word;
    end
  end

`ifdef USB_FUNC_MUX_IRQ_EN
  logic [3:0] ccr_ie_q;
  logic       conn_prev_q, conn_chg_q, irq_q;
  logic [3:0] irq_cond;

  assign ccr_ie   = ccr_ie_q;
  assign conn_chg = conn_chg_q;
  assign irq_o    = irq_q;
  // rx_nonempty, rx_ovf, tx_done (TX word free while connected), connect-change
  assign irq_cond = {conn_chg_q, active && !tx_busy_q, rx_ovf_q, !fifo_empty};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ccr_ie_q    <= '0;
      conn_prev_q <= 1'b0;
      conn_chg_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (write_i && (addr_i == AddrCcr) && data_be_i[3]) ccr_ie_q <= wdata_i[CcrIeLsb +: 4];
      conn_prev_q <= conn_sel;
      conn_chg_q  <= (active && (conn_sel != conn_prev_q)) ||
                     (conn_chg_q && !(wr_sta_lo && wdata_i[StaConnChg]));
      irq_q       <= |(ccr_ie_q & irq_cond);
    end
  end
`else
  assign ccr_ie   = '0;
  assign conn_chg = 1'b0;
`endif

  always_comb begin
    sta_word = '0;
    sta_word[StaConn]            = conn_sel;
    sta_word[StaRxEmpty]         = fifo_empty;
    sta_word[StaRxFull]          = fifo_full;
    sta_word[StaRxOvf]           = rx_ovf_q;
    sta_word[StaTxBusy]          = tx_busy_q;
    sta_word[StaSwitch]          = (state_q == StDetach);
    sta_word[StaTxOvf]           = tx_ovf_q;
    sta_word[StaConnChg]         = conn_chg;
    sta_word[StaLevelLsb +: 8]   = 8'(fifo_level);
  end

  always_comb begin
    ccr_word = '0;
    ccr_word[CcrSelLsb +: 4] = ccr_sel_q;
    ccr_word[CcrIeLsb +: 4]  = ccr_ie;
    ccr_word[CcrEn]          = ccr_en_q;
  end

  always_comb begin
    rd_word = '0;
    case (addr_i)
      AddrCcr: rd_word = ccr_word;
      AddrRdr: rd_word = fifo_empty ? 32'b0 : fifo_rdata;
      AddrSta: rd_word = sta_word;
      default: rd_word = '0;
    endcase
  end

endmodule

// File: tb/tb_usb_func_mux.sv
module tb_usb_func_mux;

  localparam int unsigned NF    = 6;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DET   = 8;

  localparam logic [3:0] ACcr = 4'h0;
  localparam logic [3:0] ARdr = 4'h4;
  localparam logic [3:0] ATdr = 4'h8;
  localparam logic [3:0] ASta = 4'hC;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              write_i = 1'b0, read_i = 1'b0;
  logic [3:0]        data_be_i = '0, addr_i = '0;
  logic [31:0]       wdata_i = '0;
  logic [31:0]       rdata_o;
  logic [NF-1:0]     func_rstn_o;
  logic [NF-1:0]     func_pull_i = '0, func_oe_i = '0, func_dp_i = '0, func_dn_i = '0;
  logic [NF-1:0]     func_conn_i = '0, func_rx_valid_i = '0, func_tx_ready_i = '0;
  logic [32*NF-1:0]  func_rx_data_i = '0;
  logic [NF-1:0]     func_rx_ready_o, func_tx_valid_o;
  logic [31:0]       func_tx_data_o;
  logic              usb_dp_pull_o, usb_oe_o, usb_dp_o, usb_dn_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];   // expected rdata per issued read
  logic [31:0] rx_model[$];

  always #5 clk_i = ~clk_i;

  usb_func_mux #(
    .N_FUNC        (NF),
    .DEPTH         (DEPTH),
    .DETACH_CYCLES (DET)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .write_i         (write_i),
    .read_i          (read_i),
    .data_be_i       (data_be_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .rdata_o         (rdata_o),
    .func_rstn_o     (func_rstn_o),
    .func_pull_i     (func_pull_i),
    .func_oe_i       (func_oe_i),
    .func_dp_i       (func_dp_i),
    .func_dn_i       (func_dn_i),
    .func_conn_i     (func_conn_i),
    .func_rx_valid_i (func_rx_valid_i),
    .func_rx_data_i  (func_rx_data_i),
    .func_rx_ready_o (func_rx_ready_o),
    .func_tx_data_o  (func_tx_data_o),
    .func_tx_valid_o (func_tx_valid_o),
    .func_tx_ready_i (func_tx_ready_i),
    .usb_dp_pull_o   (usb_dp_pull_o),
    .usb_oe_o        (usb_oe_o),
    .usb_dp_o        (usb_dp_o),
    .usb_dn_o        (usb_dn_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sta_exp(input int lvl, input bit conn, input bit empty,
                                          input bit full, input bit rovf, input bit busy,
                                          input bit sw, input bit tovf);
    return {16'b0, 8'(lvl), 1'b0, tovf, sw, busy, rovf, full, empty, conn};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write_i = 1'b1; addr_i = a; wdata_i = d; data_be_i = be;
    tick();
    write_i = 1'b0; data_be_i = '0;
  endtask

  task automatic read_expect(input string tag, input logic [3:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    read_i = 1'b1; addr_i = a;
    tick();
    read_i = 1'b0;
    check_eq(tag, rdata_o, exp_q.pop_front());
  endtask

  task automatic rx_push(input logic [31:0] w);
    func_rx_valid_i = 6'b000100;
    func_rx_data_i[2*32 +: 32] = w;
    if (rx_model.size() < DEPTH) rx_model.push_back(w);
    tick();
    func_rx_valid_i = '0;
  endtask

  initial begin
    int sw_cnt, bad, pl;
    logic [31:0] e;

    // Reset values
    #1;
    check_eq("rst_rdata", rdata_o, 32'h0);
    check_eq("rst_rstn", 32'(func_rstn_o), 32'h0);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    check_eq("rst_pads", {28'b0, usb_dp_pull_o, usb_oe_o, usb_dp_o, usb_dn_o}, 32'h0);
    check_eq("rst_rx_ready", 32'(func_rx_ready_o), 32'h0);
    read_expect("rst_sta", ASta, sta_exp(0, 0, 1, 0, 0, 0, 0, 0));

    // Select function 2; pads requested by function 2 only
    func_pull_i = 6'b000100; func_oe_i = 6'b000100;
    func_dp_i   = 6'b000100; func_dn_i = 6'b111011;
    func_conn_i = 6'b000100;
    bus_write(ACcr, 32'h8000_0002, 4'hF);
    check_eq("detach_pull", 32'(usb_dp_pull_o), 32'h0);
    check_eq("detach_rstn", 32'(func_rstn_o), 32'h0);
    read_i = 1'b1; addr_i = ASta; sw_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rdata_o[5]) sw_cnt++;
    end
    read_i = 1'b0;
    check_eq("switch_cycles", 32'(sw_cnt), 32'd8);
    check_eq("active_rstn", 32'(func_rstn_o), 32'b000100);
    check_eq("pads_a", {28'b0, usb_dp_pull_o, usb_oe_o, usb_dp_o, usb_dn_o}, 32'b1110);
    func_pull_i = 6'b111011; func_oe_i = 6'b111011;
    func_dp_i   = 6'b111011; func_dn_i = 6'b000100;
    #1;
    check_eq("pads_b", {28'b0, usb_dp_pull_o, usb_oe_o, usb_dp_o, usb_dn_o}, 32'b0001);
    func_pull_i = 6'b000100; func_oe_i = 6'b000100;

    // Overfill the RX FIFO
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check_eq("rx_ready_full", 32'(func_rx_ready_o), 32'h0);
      rx_push(32'hC0DE_0000 + 32'(i));
    end
    read_expect("sta_full", ASta, sta_exp(16, 1, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 17; i++) begin
      e = (rx_model.size() != 0) ? rx_model.pop_front() : 32'h0;
      read_expect($sformatf("rdr_%0d", i), ARdr, e);
    end
    bus_write(ASta, 32'h0000_0008, 4'h1);
    read_expect("sta_rx_ovf_clr", ASta, sta_exp(0, 1, 1, 0, 0, 0, 0, 0));

    // TX with stalled ready
    bus_write(ATdr, 32'hA5A5_A5A5, 4'hF);
    check_eq("tx_valid", 32'(func_tx_valid_o), 32'b000100);
    check_eq("tx_data", func_tx_data_o, 32'hA5A5_A5A5);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (func_tx_valid_o != 6'b000100) bad++;
    end
    check_eq("tx_valid_hold", 32'(bad), 32'h0);
    bus_write(ATdr, 32'h1234_5678, 4'hF);
    check_eq("tx_data_kept", func_tx_data_o, 32'hA5A5_A5A5);
    read_expect("sta_tx_ovf", ASta, sta_exp(0, 1, 1, 0, 0, 1, 0, 1));
    func_tx_ready_i = 6'b000100;
    tick();
    func_tx_ready_i = '0;
    check_eq("tx_done_valid", 32'(func_tx_valid_o), 32'h0);
    read_expect("sta_tx_done", ASta, sta_exp(0, 1, 1, 0, 0, 0, 0, 1));
    bus_write(ASta, 32'h0000_0040, 4'h1);
    read_expect("sta_tx_ovf_clr", ASta, sta_exp(0, 1, 1, 0, 0, 0, 0, 0));

    // Switch to function 4 mid-transfer
    bus_write(ATdr, 32'h1111_2222, 4'hF);
    for (int i = 0; i < 3; i++) rx_push(32'hBEEF_0000 + 32'(i));
    read_expect("sta_mid", ASta, sta_exp(3, 1, 0, 0, 0, 1, 0, 0));
    func_pull_i = 6'b010100;
    bus_write(ACcr, 32'h8000_0004, 4'hF);
    rx_model.delete();
    check_eq("switch_tx_valid", 32'(func_tx_valid_o), 32'h0);
    pl = 0;
    while (pl < 20 && !usb_dp_pull_o) begin
      pl++;
      tick();
    end
    check_eq("pull_low_cycles", 32'(pl), 32'd8);
    check_eq("fn4_rstn", 32'(func_rstn_o), 32'b010000);
    read_expect("sta_fn4", ASta, sta_exp(0, 0, 1, 0, 0, 0, 0, 0));
    bus_write(ATdr, 32'hDEAD_BEEF, 4'b0101);
    check_eq("tx_be_mask", func_tx_data_o, 32'h00AD_00EF);
    check_eq("tx_valid_fn4", 32'(func_tx_valid_o), 32'b010000);
    func_tx_ready_i = 6'b010000;
    tick();
    func_tx_ready_i = '0;

    // Out-of-range select falls back to IDLE
    bus_write(ACcr, 32'h8000_0009, 4'hF);
    repeat (12) tick();
    check_eq("sel9_rstn", 32'(func_rstn_o), 32'h0);
    check_eq("sel9_pull", 32'(usb_dp_pull_o), 32'h0);
    read_expect("ccr_rb", ACcr, 32'h8000_0009);
    read_expect("sta_idle", ASta, sta_exp(0, 0, 1, 0, 0, 0, 0, 0));
    bus_write(ATdr, 32'h5555_5555, 4'hF);
    read_expect("sta_idle_tx_ovf", ASta, sta_exp(0, 0, 1, 0, 0, 0, 0, 1));

    // Asynchronous reset in the middle of a detach
    bus_write(ACcr, 32'h8000_0002, 4'hF);
    repeat (3) tick();
    read_expect("sta_detach", ASta, sta_exp(0, 0, 1, 0, 0, 0, 1, 1));
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_rdata", rdata_o, 32'h0);
    tick();
    rst_i = 1'b0;
    repeat (12) tick();
    check_eq("post_rst_rstn", 32'(func_rstn_o), 32'h0);
    read_expect("post_rst_sta", ASta, sta_exp(0, 0, 1, 0, 0, 0, 0, 0));
    read_expect("post_rst_ccr", ACcr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
